// File: rtl/control_unit.sv
// Multicycle MIPS-subset control FSM driving all datapath enables and mux selects.
// Latency: Moore outputs from the state register; FETCH and MEM_RD each last MEM_WAIT+1 cycles.
// No backpressure: memory timing is fixed by MEM_WAIT, and the FSM never stalls on handshakes.
module control_unit #(
    parameter int MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       pc_w,
    output logic       iord,
    output logic       mem_w,
    output logic       ir_w,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       epc_w,
    output logic [1:0] cause,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_R_WB     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_I_WB     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_LW_WB    = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_EXC      = 4'd13
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] CAUSE_INVALID  = 2'b01;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'b10;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_t     state, state_next;
    logic [2:0] wait_cnt;
    logic [1:0] exc_cause, exc_cause_next;
    logic       wait_done;
    logic       funct_valid;
    logic       funct_arith;

    assign wait_done   = (wait_cnt == WAIT_LAST);
    assign funct_valid = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                         (funct == 6'h25) || (funct == 6'h2A);
    // Only signed add/sub can trap; logical ops and SLT ignore the ALU overflow flag.
    assign funct_arith = (funct == 6'h20) || (funct == 6'h22);

    // State register, memory wait counter (cleared on every transition) and latched trap cause.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_RST;
            wait_cnt  <= 3'd0;
            exc_cause <= 2'b00;
        end else begin
            state     <= state_next;
            exc_cause <= exc_cause_next;
            if (state_next != state)
                wait_cnt <= 3'd0;
            else if (wait_cnt != 3'd7)
                wait_cnt <= wait_cnt + 3'd1;
        end
    end

    // Next-state selection and the reason recorded when entering the exception state.
    always_comb begin
        state_next     = state;
        exc_cause_next = exc_cause;
        case (state)
            S_RST:    state_next = S_FETCH;
            S_FETCH:  if (wait_done) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    6'h00: begin
                        if (funct_valid) begin
                            state_next = S_EXEC_R;
                        end else begin
                            state_next     = S_EXC;
                            exc_cause_next = CAUSE_INVALID;
                        end
                    end
                    6'h08:        state_next = S_EXEC_I;
                    6'h23, 6'h2B: state_next = S_MEM_ADDR;
                    6'h04, 6'h05: state_next = S_BRANCH;
                    6'h02:        state_next = S_JUMP;
                    default: begin
                        state_next     = S_EXC;
                        exc_cause_next = CAUSE_INVALID;
                    end
                endcase
            end
            S_EXEC_R: begin
                if (overflow && funct_arith) begin
                    state_next     = S_EXC;
                    exc_cause_next = CAUSE_OVERFLOW;
                end else begin
                    state_next = S_R_WB;
                end
            end
            S_EXEC_I: begin
                if (overflow) begin
                    state_next     = S_EXC;
                    exc_cause_next = CAUSE_OVERFLOW;
                end else begin
                    state_next = S_I_WB;
                end
            end
            S_MEM_ADDR: state_next = (opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (wait_done) state_next = S_LW_WB;
            S_R_WB, S_I_WB, S_LW_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_EXC:
                        state_next = S_FETCH;
            default:    state_next = S_RST;
        endcase
    end

    // Datapath controls decoded from the current state; BRANCH alone also looks at zero.
    always_comb begin
        pc_w       = 1'b0;
        iord       = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        pc_source  = 2'b00;
        epc_w      = 1'b0;
        cause      = 2'b00;
        case (state)
            S_FETCH: begin
                if (wait_done) begin
                    ir_w      = 1'b1;
                    pc_w      = 1'b1;
                    alu_src_b = 2'b01;
                    alu_op    = ALU_ADD;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = ALU_ADD;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'h20:   alu_op = ALU_ADD;
                    6'h22:   alu_op = ALU_SUB;
                    6'h24:   alu_op = ALU_AND;
                    6'h25:   alu_op = ALU_OR;
                    6'h2A:   alu_op = ALU_SLT;
                    default: alu_op = 3'b000;
                endcase
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALU_ADD;
            end
            S_I_WB:   reg_write = 1'b1;
            S_MEM_RD: iord = 1'b1;
            S_LW_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                iord  = 1'b1;
                mem_w = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = 2'b01;
                pc_w      = ((opcode == 6'h04) && zero) || ((opcode == 6'h05) && !zero);
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_w      = 1'b1;
            end
            S_EXC: begin
                epc_w     = 1'b1;
                pc_w      = 1'b1;
                pc_source = 2'b11;
                cause     = exc_cause;
            end
            default: ;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: two instances (MEM_WAIT=1 and MEM_WAIT=2) driven from expected-cycle tables.
// Each instruction is expanded into its expected per-cycle control vector from the ISA timing rules.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
module tb_control_unit;

    localparam logic [3:0] ST_RST = 4'd0,  ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_EXEC_R = 4'd3,
                           ST_R_WB = 4'd4, ST_EXEC_I = 4'd5, ST_I_WB = 4'd6, ST_MEM_ADDR = 4'd7,
                           ST_MEM_RD = 4'd8, ST_LW_WB = 4'd9, ST_MEM_WR = 4'd10, ST_BRANCH = 4'd11,
                           ST_JUMP = 4'd12, ST_EXC = 4'd13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst_v;
    logic [1:0][5:0] op_v, fn_v;
    logic [1:0]      z_v, ov_v;
    logic [1:0]      pc_w_v, iord_v, mem_w_v, ir_w_v, rw_v, rd_v, mtr_v, sa_v, epc_v;
    logic [1:0][1:0] sb_v, pcs_v, cause_v;
    logic [1:0][2:0] aop_v;
    logic [1:0][3:0] st_v;
    logic [1:0][21:0] obs;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        control_unit #(.MEM_WAIT(g + 1)) u_dut (
            .clk(clk), .reset(rst_v[g]), .opcode(op_v[g]), .funct(fn_v[g]),
            .zero(z_v[g]), .overflow(ov_v[g]),
            .pc_w(pc_w_v[g]), .iord(iord_v[g]), .mem_w(mem_w_v[g]), .ir_w(ir_w_v[g]),
            .reg_write(rw_v[g]), .reg_dst(rd_v[g]), .mem_to_reg(mtr_v[g]), .alu_src_a(sa_v[g]),
            .alu_src_b(sb_v[g]), .alu_op(aop_v[g]), .pc_source(pcs_v[g]), .epc_w(epc_v[g]),
            .cause(cause_v[g]), .state_dbg(st_v[g])
        );
        assign obs[g] = {pc_w_v[g], iord_v[g], mem_w_v[g], ir_w_v[g], rw_v[g], rd_v[g], mtr_v[g],
                         sa_v[g], sb_v[g], aop_v[g], pcs_v[g], epc_v[g], cause_v[g], st_v[g]};
    end

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        ov;
        logic [21:0] exp;
    } item_t;

    item_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic [5:0] cur_op, cur_fn;
    logic       cur_z, cur_ov;

    // Control vector in the same field order as obs.
    function automatic logic [21:0] mk(input logic pcw, iord, memw, irw, rw, rd, mtr, sa,
                                       input logic [1:0] sb, input logic [2:0] aop,
                                       input logic [1:0] pcs, input logic epc,
                                       input logic [1:0] cs, input logic [3:0] st);
        return {pcw, iord, memw, irw, rw, rd, mtr, sa, sb, aop, pcs, epc, cs, st};
    endfunction

    task automatic emit(input logic [21:0] e);
        item_t it;
        it.rst = 1'b1; it.op = cur_op; it.fn = cur_fn; it.z = cur_z; it.ov = cur_ov; it.exp = e;
        q.push_back(it);
    endtask

    // Reset held low for n cycles (all outputs 0), then one released cycle still in RST.
    task automatic add_reset(input int n);
        item_t it;
        it.op = 6'h00; it.fn = 6'h00; it.z = 1'b0; it.ov = 1'b0; it.exp = 22'd0;
        for (int i = 0; i < n; i++) begin
            it.rst = 1'b0;
            q.push_back(it);
        end
        it.rst = 1'b1;
        q.push_back(it);
    endtask

    task automatic emit_exc(input logic [1:0] c);
        emit(mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b11, 1, c, ST_EXC));
    endtask

    // Expected cycle-by-cycle controls for one complete instruction.
    task automatic add_instr(input int mw, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic ov);
        logic [2:0] aop;
        cur_op = op; cur_fn = fn; cur_z = z; cur_ov = ov;
        for (int i = 0; i < mw; i++)
            emit(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 2'b00, ST_FETCH));
        emit(mk(1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 3'b001, 2'b00, 0, 2'b00, ST_FETCH));
        emit(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b001, 2'b00, 0, 2'b00, ST_DECODE));
        if (op == 6'h00 && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
            aop = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 :
                  (fn == 6'h25) ? 3'b100 : 3'b111;
            emit(mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, aop, 2'b00, 0, 2'b00, ST_EXEC_R));
            if (ov && (fn == 6'h20 || fn == 6'h22)) emit_exc(2'b10);
            else emit(mk(0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 3'b000, 2'b00, 0, 2'b00, ST_R_WB));
        end else if (op == 6'h08) begin
            emit(mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b001, 2'b00, 0, 2'b00, ST_EXEC_I));
            if (ov) emit_exc(2'b10);
            else emit(mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 2'b00, ST_I_WB));
        end else if (op == 6'h23 || op == 6'h2B) begin
            emit(mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b001, 2'b00, 0, 2'b00, ST_MEM_ADDR));
            if (op == 6'h23) begin
                for (int i = 0; i <= mw; i++)
                    emit(mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 2'b00, ST_MEM_RD));
                emit(mk(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 2'b00, ST_LW_WB));
            end else begin
                emit(mk(0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 2'b00, ST_MEM_WR));
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            emit(mk((op == 6'h04) ? z : !z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 2'b01, 0,
                    2'b00, ST_BRANCH));
        end else if (op == 6'h02) begin
            emit(mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 0, 2'b00, ST_JUMP));
        end else begin
            emit_exc(2'b01);
        end
    endtask

    // Hand-computed literals that pin the model's own tables.
    task automatic pin(input string name, input logic [21:0] got, input logic [21:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL pin %s: model %b required %b", name, got, want);
        end
    endtask

    task automatic pin_len(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL len %s: model %0d cycles required %0d", name, got, want);
        end
    endtask

    // Plays the table into one instance and compares every cycle.
    task automatic run(input int sel);
        for (int i = 0; i < q.size(); i++) begin
            @(posedge clk);
            #1;
            rst_v[sel] = q[i].rst; op_v[sel] = q[i].op; fn_v[sel] = q[i].fn;
            z_v[sel] = q[i].z; ov_v[sel] = q[i].ov;
            @(negedge clk);
            n_cmp++;
            if (obs[sel] !== q[i].exp) begin
                n_bad++;
                $display("FAIL dut%0d step %0d (op %h fn %h): got %b required %b",
                         sel, i, q[i].op, q[i].fn, obs[sel], q[i].exp);
            end
        end
        q.delete();
    endtask

    initial begin
        int s;
        rst_v = 2'b11; op_v = '0; fn_v = '0; z_v = '0; ov_v = '0;
        #2 rst_v[1] = 1'b0;

        // MEM_WAIT = 1 instance
        add_reset(3);
        s = q.size();
        add_instr(1, 6'h00, 6'h20, 0, 0);
        pin_len("add", q.size() - s, 5);
        pin("fetch_final", q[s + 1].exp, 22'b10010000_01_001_00_0_00_0001);
        pin("r_wb", q[s + 4].exp, 22'b00001100_00_000_00_0_00_0100);
        s = q.size();
        add_instr(1, 6'h08, 6'h00, 0, 1);
        pin("exc_ovf", q[s + 4].exp, 22'b10000000_00_000_11_1_10_1101);
        add_instr(1, 6'h00, 6'h22, 0, 1);
        add_instr(1, 6'h00, 6'h24, 0, 1);
        add_instr(1, 6'h00, 6'h2A, 0, 1);
        add_instr(1, 6'h00, 6'h25, 0, 0);
        add_instr(1, 6'h00, 6'h00, 0, 0);
        add_instr(1, 6'h04, 6'h00, 0, 0);
        add_instr(1, 6'h04, 6'h00, 1, 1);
        s = q.size();
        add_instr(1, 6'h05, 6'h00, 0, 0);
        pin("bne_taken", q[s + 3].exp, 22'b10000001_00_010_01_0_00_1011);
        add_instr(1, 6'h05, 6'h00, 1, 0);
        add_instr(1, 6'h02, 6'h00, 0, 0);
        s = q.size();
        add_instr(1, 6'h3F, 6'h00, 0, 0);
        pin("exc_invalid", q[s + 3].exp, 22'b10000000_00_000_11_1_01_1101);
        add_instr(1, 6'h08, 6'h00, 0, 0);
        add_instr(1, 6'h23, 6'h00, 0, 1);
        s = q.size();
        add_instr(1, 6'h2B, 6'h00, 0, 1);
        pin("mem_wr", q[s + 4].exp, 22'b01100000_00_000_00_0_00_1010);
        // Store cut short by reset in its MEM_WR cycle: mem_w must drop immediately.
        add_instr(1, 6'h2B, 6'h00, 0, 0);
        void'(q.pop_back());
        add_reset(2);
        add_instr(1, 6'h00, 6'h20, 0, 0);
        run(0);
        rst_v[0] = 1'b0;

        // MEM_WAIT = 2 instance
        add_reset(3);
        s = q.size();
        add_instr(2, 6'h23, 6'h00, 0, 0);
        pin_len("lw_mw2", q.size() - s, 9);
        pin("lw_wb", q[s + 8].exp, 22'b00001010_00_000_00_0_00_1001);
        add_instr(2, 6'h2B, 6'h00, 0, 0);
        add_instr(2, 6'h00, 6'h22, 1, 0);
        add_instr(2, 6'h05, 6'h00, 1, 0);
        run(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
